// File: rtl/serial_cfg_tx.sv
// serial_cfg_tx: backend power-up sequencer (reset hold, 5-bit gain shift-out, ready wait with timeout)
module serial_cfg_tx #(
    parameter int CLKDIV           = 2,
    parameter int RESET_LOW_CYCLES = 4,
    parameter int READY_TIMEOUT    = 64
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [1:0] i_gainA1,
    input  logic [2:0] i_gainA2,
    input  logic       i_ready,
    output logic       o_resetbAll,
    output logic       o_sclk,
    output logic       o_sdin,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_timeout
);
    localparam int MAX_AB = (RESET_LOW_CYCLES > 2 * CLKDIV) ? RESET_LOW_CYCLES : 2 * CLKDIV;
    localparam int MAXP   = (MAX_AB > READY_TIMEOUT) ? MAX_AB : READY_TIMEOUT;
    localparam int CW     = $clog2(MAXP) + 1;

    typedef enum logic [2:0] {IDLE, RST_LOW, SHIFT, WAIT_READY, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [4:0]    sh;
    logic [1:0]    rdy_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            sh          <= '0;
            rdy_q       <= '0;
            o_resetbAll <= 1'b0;
            o_sclk      <= 1'b0;
            o_sdin      <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            rdy_q  <= {rdy_q[0], i_ready};
            o_done <= 1'b0;
            case (state)
                IDLE: if (i_start) begin
                    sh          <= {i_gainA2, i_gainA1};
                    o_timeout   <= 1'b0;
                    o_busy      <= 1'b1;
                    o_resetbAll <= 1'b0;
                    cnt         <= '0;
                    state       <= RST_LOW;
                end
                RST_LOW: if (cnt == CW'(RESET_LOW_CYCLES - 1)) begin
                    o_resetbAll <= 1'b1;
                    o_sdin      <= sh[0];
                    sh          <= sh >> 1;
                    cnt         <= '0;
                    bit_idx     <= '0;
                    state       <= SHIFT;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                SHIFT: if (cnt == CW'(2 * CLKDIV - 1)) begin
                    cnt    <= '0;
                    o_sclk <= 1'b0;
                    if (bit_idx == 3'd4) begin
                        o_sdin <= 1'b0;
                        state  <= WAIT_READY;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                        o_sdin  <= sh[0];
                        sh      <= sh >> 1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(CLKDIV - 1)) o_sclk <= 1'b1;
                end
                WAIT_READY: if (rdy_q[1] || cnt == CW'(READY_TIMEOUT)) begin
                    o_timeout <= !rdy_q[1];
                    o_done    <= 1'b1;
                    state     <= DONE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_cfg_tx.sv
// tb_serial_cfg_tx: randomized scoreboard bench with a loopback backend receiver for serial_cfg_tx
module tb_serial_cfg_tx;
    localparam int CD    = 2;
    localparam int RLC   = 4;
    localparam int RT    = 64;
    localparam int ENTRY = RLC + 10 * CD;
    localparam int NEVER = 1000;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic       rdy   = 1'b0;
    logic [1:0] a1    = '0;
    logic [2:0] a2    = '0;
    logic       resetb, sclk, sdin, busy, done, tout;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct {
        logic [1:0] a1;
        logic [2:0] a2;
        logic       to;
        int         done_cyc;
    } exp_t;
    exp_t sb[$];

    logic [4:0] rx        = '0;
    int         rx_cnt    = 0;
    logic       prev_sclk = 1'b0;

    serial_cfg_tx #(.CLKDIV(CD), .RESET_LOW_CYCLES(RLC), .READY_TIMEOUT(RT)) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_start(start),
        .i_gainA1(a1),
        .i_gainA2(a2),
        .i_ready(rdy),
        .o_resetbAll(resetb),
        .o_sclk(sclk),
        .o_sdin(sdin),
        .o_busy(busy),
        .o_done(done),
        .o_timeout(tout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic exp_sclk(input int e);
        int s;
        s = e - RLC;
        return (s >= 0 && s < 10 * CD) ? ((s / CD) % 2 == 1) : 1'b0;
    endfunction

    function automatic logic exp_sdin(input int e, input logic [4:0] bits);
        int s;
        s = e - RLC;
        if (s < 0 || s >= 10 * CD) return 1'b0;
        return bits[s / (2 * CD)];
    endfunction

    // Backend receiver: samples sdin on each sclk rise, cleared while held in reset.
    // On each done pulse the oldest expected transaction is popped and compared.
    always @(negedge clk) begin
        if (!resetb) rx_cnt = 0;
        else if (sclk && !prev_sclk) begin
            if (rx_cnt < 5) rx[rx_cnt] = sdin;
            rx_cnt++;
        end
        prev_sclk = sclk;
        if (done) begin
            check("done_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                exp_t x;
                x = sb.pop_front();
                check("rx_bits", rx_cnt, 5);
                check("rx_gainA1", rx[1:0], x.a1);
                check("rx_gainA2", rx[4:2], x.a2);
                check("timeout_flag", tout, x.to);
                check("done_cycle", cyc, x.done_cyc);
            end
        end
    end

    // d: cycles after WAIT_READY entry at which ready rises (NEVER = no ready)
    // spur: cycle after accept at which a spurious start is pulsed (-1 = none)
    task automatic run_txn(input logic [1:0] g1, input logic [2:0] g2, input int d, input int spur);
        int         dexp, t0, e;
        logic       to_exp;
        logic [4:0] bits;
        bits   = {g2, g1};
        to_exp = (d + 3 > RT + 1);
        dexp   = ENTRY + (to_exp ? RT + 1 : d + 3);
        @(negedge clk); #1;
        start = 1'b1;
        a1    = g1;
        a2    = g2;
        @(posedge clk);
        @(negedge clk); #1;
        t0 = cyc;
        sb.push_back('{a1: g1, a2: g2, to: to_exp, done_cyc: t0 + dexp});
        a1 = 2'($urandom);
        a2 = 3'($urandom);
        check("timeout_cleared", tout, 0);
        e = 0;
        forever begin
            if (e <= dexp) begin
                check("resetb", resetb, e >= RLC);
                check("sclk", sclk, exp_sclk(e));
                check("sdin", sdin, exp_sdin(e, bits));
                check("busy", busy, 1);
            end
            if (e == spur) begin
                start = 1'b1;
                a1    = 2'($urandom);
                a2    = 3'($urandom);
            end else begin
                start = 1'b0;
            end
            if (e == ENTRY + d) rdy = 1'b1;
            if (sb.size() == 0 || e > dexp + 10) break;
            @(negedge clk); #1;
            e++;
        end
        check("done_seen", sb.size(), 0);
        sb.delete();
        @(negedge clk); #1;
        check("busy_idle", busy, 0);
        check("done_width", done, 0);
        check("timeout_sticky", tout, to_exp);
        rdy   = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_resetb"}, resetb, 0);
        check({tag, "_sclk"}, sclk, 0);
        check({tag, "_sdin"}, sdin, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_timeout"}, tout, 0);
    endtask

    initial begin
        rst = 1'b1;
        #1;
        check_reset_outputs("por");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_txn(2'b10, 3'b101, 20, -1);
        run_txn(2'b10, 3'b101, NEVER, -1);
        run_txn(2'b10, 3'b101, RT - 2, -1);
        run_txn(2'b10, 3'b101, RT - 1, -1);
        run_txn(2'b10, 3'b101, 5, 11);

        // reset in the middle of the frame
        @(negedge clk); #1;
        start = 1'b1;
        a1    = 2'b10;
        a2    = 3'b101;
        @(posedge clk);
        @(negedge clk); #1;
        start = 1'b0;
        repeat (13) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        repeat (4) begin
            @(negedge clk); #1;
            check("midreset_hold_sclk", sclk, 0);
            check("midreset_hold_resetb", resetb, 0);
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk); #1;
            check("postreset_sclk", sclk, 0);
            check("postreset_busy", busy, 0);
        end
        run_txn(2'b10, 3'b101, 10, -1);

        for (int i = 0; i < 32; i++)
            run_txn(i[1:0], i[4:2], int'($urandom_range(0, 40)),
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, ENTRY - 1)) : -1);

        for (int i = 0; i < 8; i++)
            run_txn(2'($urandom), 3'($urandom),
                    ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(0, 70)),
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, ENTRY - 1)) : -1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
